// File: rtl/cfg_shift_loader.sv
// Serial configuration loader: fills a shadow register LANES bits per enable beat and
// transfers it to the active configuration on commit, with chaining, abort and lock.
module cfg_shift_loader #(
  parameter int N         = 32,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit ONE_SHOT  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [LANES-1:0] data_in,
  input  logic             commit,
  input  logic             abort,
  output logic [N-1:0]     data_out,
  output logic [LANES-1:0] data_so,
  output logic             loaded,
  output logic             locked,
  output logic             commit_err
);

  localparam int BEATS = N / LANES;
  localparam int CW    = $clog2(BEATS + 1);

  if (N < 1 || LANES < 1 || (N % LANES) != 0) begin : g_bad_params
    $error("cfg_shift_loader: N must be a positive multiple of LANES");
  end

  logic [N-1:0]  shadow;
  logic [N-1:0]  shift_next;
  logic [CW-1:0] count;
  logic          locked_q;

  // Newest beat enters at the low end (MSB first) or the high end (LSB first), so the
  // oldest retained beat is always the one presented on data_so.
  if (N == LANES) begin : g_single
    assign shift_next = data_in;
    assign data_so    = shadow;
  end else if (MSB_FIRST) begin : g_msb
    assign shift_next = {shadow[N-LANES-1:0], data_in};
    assign data_so    = shadow[N-1 -: LANES];
  end else begin : g_lsb
    assign shift_next = {data_in, shadow[N-1:LANES]};
    assign data_so    = shadow[LANES-1:0];
  end

  assign loaded = (count == CW'(BEATS));
  assign locked = ONE_SHOT && locked_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would let shadow/count ordering change behaviour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow     <= '0;
      count      <= '0;
      data_out   <= '0;
      locked_q   <= 1'b0;
      commit_err <= 1'b0;
    end else if (!locked) begin
      if (abort) begin
        shadow <= '0;
        count  <= '0;
      end else if (commit) begin
        // Shadow is kept on commit so a downstream loader can still be fed from data_so.
        if (loaded) begin
          data_out <= shadow;
          if (ONE_SHOT) locked_q <= 1'b1;
        end else begin
          commit_err <= 1'b1;
        end
        count <= '0;
      end else if (enable) begin
        shadow <= shift_next;
        if (!loaded) count <= count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cfg_shift_loader.sv
// Bench for cfg_shift_loader: four configurations driven by shared controls and checked
// every cycle against a beat-history reference model plus directed constant expectations.
module tb_cfg_shift_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable, commit, abort;
  logic       din0;
  logic [1:0] din1, din2;
  logic [3:0] din3;

  logic [7:0] do0, do1, do2;
  logic [3:0] do3;
  logic       so0;
  logic [1:0] so1, so2;
  logic [3:0] so3;
  logic [3:0] ld, lk, er;

  logic [7:0] dut_do[4];
  logic [3:0] dut_so[4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u0: N=8 L=1 MSB one-shot; u1: N=8 L=2 MSB reloadable;
  // u2: N=8 L=2 LSB reloadable; u3: N=4 L=4 LSB reloadable (single beat).
  cfg_shift_loader #(.N(8), .LANES(1), .MSB_FIRST(1'b1), .ONE_SHOT(1'b1)) u0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(din0), .commit(commit),
    .abort(abort), .data_out(do0), .data_so(so0), .loaded(ld[0]), .locked(lk[0]),
    .commit_err(er[0]));
  cfg_shift_loader #(.N(8), .LANES(2), .MSB_FIRST(1'b1), .ONE_SHOT(1'b0)) u1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(din1), .commit(commit),
    .abort(abort), .data_out(do1), .data_so(so1), .loaded(ld[1]), .locked(lk[1]),
    .commit_err(er[1]));
  cfg_shift_loader #(.N(8), .LANES(2), .MSB_FIRST(1'b0), .ONE_SHOT(1'b0)) u2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(din2), .commit(commit),
    .abort(abort), .data_out(do2), .data_so(so2), .loaded(ld[2]), .locked(lk[2]),
    .commit_err(er[2]));
  cfg_shift_loader #(.N(4), .LANES(4), .MSB_FIRST(1'b0), .ONE_SHOT(1'b0)) u3 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(din3), .commit(commit),
    .abort(abort), .data_out(do3), .data_so(so3), .loaded(ld[3]), .locked(lk[3]),
    .commit_err(er[3]));

  assign dut_do[0] = do0;
  assign dut_do[1] = do1;
  assign dut_do[2] = do2;
  assign dut_do[3] = {4'h0, do3};
  assign dut_so[0] = {3'b000, so0};
  assign dut_so[1] = {2'b00, so1};
  assign dut_so[2] = {2'b00, so2};
  assign dut_so[3] = so3;

  // Reference model: the most recent beats received (hist[i][0] newest), beats since clear,
  // plus committed value, lock and sticky error.
  int n_w[4]   = '{8, 8, 8, 4};
  int lanes[4] = '{1, 2, 2, 4};
  bit msb[4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
  bit osh[4]   = '{1'b1, 1'b0, 1'b0, 1'b0};
  int hist[4][8];
  int cnt[4];
  logic [7:0] m_do[4];
  bit m_lk[4];
  bit m_er[4];

  function automatic int beats(int i);
    return n_w[i] / lanes[i];
  endfunction

  // Assemble the shadow from the retained beats: MSB first puts the newest beat at the
  // bottom, LSB first puts it at the top.
  function automatic logic [7:0] m_shadow(int i);
    int v = 0;
    for (int k = 0; k < beats(i); k++) begin
      if (msb[i]) v += hist[i][k] << (k * lanes[i]);
      else        v += hist[i][k] << (n_w[i] - lanes[i] * (k + 1));
    end
    return 8'(v);
  endfunction

  function automatic int din_of(int i);
    case (i)
      0:       return int'(din0);
      1:       return int'(din1);
      2:       return int'(din2);
      default: return int'(din3);
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) hist[i][k] = 0;
      cnt[i] = 0; m_do[i] = 8'h00; m_lk[i] = 1'b0; m_er[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 4; i++) begin
      if (m_lk[i]) continue;
      if (abort) begin
        for (int k = 0; k < 8; k++) hist[i][k] = 0;
        cnt[i] = 0;
      end else if (commit) begin
        if (cnt[i] == beats(i)) begin
          m_do[i] = m_shadow(i);
          if (osh[i]) m_lk[i] = 1'b1;
        end else begin
          m_er[i] = 1'b1;
        end
        cnt[i] = 0;
      end else if (enable) begin
        for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = din_of(i);
        if (cnt[i] < beats(i)) cnt[i]++;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s u%0d data_out", ph, i), dut_do[i], m_do[i]);
      check($sformatf("%s u%0d data_so", ph, i), {4'h0, dut_so[i]}, 8'(hist[i][beats(i)-1]));
      check($sformatf("%s u%0d loaded", ph, i), {7'h0, ld[i]}, {7'h0, cnt[i] == beats(i)});
      check($sformatf("%s u%0d locked", ph, i), {7'h0, lk[i]}, {7'h0, m_lk[i]});
      check($sformatf("%s u%0d commit_err", ph, i), {7'h0, er[i]}, {7'h0, m_er[i]});
    end
  endtask

  task automatic step(input bit en, input bit cm, input bit ab,
                      input logic d0, input logic [1:0] d12);
    enable = en; commit = cm; abort = ab;
    din0 = d0; din1 = d12; din2 = d12; din3 = 4'($urandom);
    @(posedge clk);
    model_edge();
    #1;
    check_all("step");
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all("reset");
    reset_n = 1'b1;
  endtask

  initial begin
    logic [9:0] pat;
    reset_n = 1'b1; enable = 1'b0; commit = 1'b0; abort = 1'b0;
    din0 = 1'b0; din1 = 2'b00; din2 = 2'b00; din3 = 4'h0;
    model_reset();
    #1;
    do_reset();

    // Short load then commit flags an error; a full load afterwards still commits.
    for (int k = 0; k < 5; k++) step(1, 0, 0, 1'($urandom), 2'($urandom));
    step(0, 1, 0, 1'b0, 2'b00);
    check("t2 err set", {7'h0, er[0]}, 8'h01);
    check("t2 dout kept", do0, 8'h00);
    check("t2 not loaded", {7'h0, ld[0]}, 8'h00);
    pat = 10'h03C;
    for (int k = 7; k >= 0; k--) step(1, 0, 0, pat[k], 2'($urandom));
    step(0, 1, 0, 1'b0, 2'b00);
    check("t2 dout 3c", do0, 8'h3C);
    check("t2 err sticky", {7'h0, er[0]}, 8'h01);

    // One-shot: commit locks, later loads and commits are ignored.
    do_reset();
    pat = 10'h0A5;
    for (int k = 7; k >= 0; k--) step(1, 0, 0, pat[k], 2'($urandom));
    step(0, 1, 0, 1'b0, 2'b00);
    check("t1 dout a5", do0, 8'hA5);
    check("t1 locked", {7'h0, lk[0]}, 8'h01);
    for (int k = 0; k < 8; k++) step(1, 0, 0, 1'($urandom), 2'($urandom));
    step(0, 1, 0, 1'b0, 2'b00);
    step(1, 0, 1, 1'b1, 2'b11);
    check("t1 dout held", do0, 8'hA5);

    // Two lanes, both bit orders.
    do_reset();
    step(1, 0, 0, 1'b0, 2'b10);
    step(1, 0, 0, 1'b0, 2'b11);
    step(1, 0, 0, 1'b0, 2'b00);
    step(1, 0, 0, 1'b0, 2'b01);
    step(0, 1, 0, 1'b0, 2'b00);
    check("t3 msb b1", do1, 8'hB1);
    check("t3 lsb 4e", do2, 8'h4E);

    // Reloadable: successive commits replace data_out.
    step(1, 0, 0, 1'b0, 2'b00);
    step(1, 0, 0, 1'b0, 2'b11);
    step(1, 0, 0, 1'b0, 2'b11);
    step(1, 0, 0, 1'b0, 2'b00);
    step(0, 1, 0, 1'b0, 2'b00);
    check("t4 dout 3c", do1, 8'h3C);
    step(1, 0, 0, 1'b0, 2'b11);
    step(1, 0, 0, 1'b0, 2'b00);
    step(1, 0, 0, 1'b0, 2'b00);
    step(1, 0, 0, 1'b0, 2'b11);
    step(0, 1, 0, 1'b0, 2'b00);
    check("t4 dout c3", do1, 8'hC3);
    check("t4 unlocked", {7'h0, lk[1]}, 8'h00);

    // Reset mid-load loses the partial load; abort discards one too.
    do_reset();
    for (int k = 0; k < 4; k++) step(1, 0, 0, 1'($urandom), 2'($urandom));
    do_reset();
    check("t5 rst loaded", {7'h0, ld[1]}, 8'h00);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 1'($urandom), 2'($urandom));
    step(0, 1, 0, 1'b0, 2'b00);
    check("t5 err after rst", {7'h0, er[0]}, 8'h01);
    do_reset();
    for (int k = 0; k < 6; k++) step(1, 0, 0, 1'($urandom), 2'($urandom));
    step(1, 0, 1, 1'b1, 2'b11);
    pat = 10'($urandom);
    for (int k = 7; k >= 0; k--) step(1, 0, 0, pat[k], 2'($urandom));
    step(0, 1, 0, 1'b0, 2'b00);
    check("t5 abort then load", do0, pat[7:0]);
    check("t5 no err", {7'h0, er[0]}, 8'h00);

    // Over-shift keeps the last beats; commit with enable drops the shift.
    do_reset();
    pat = 10'h2A5;
    for (int k = 9; k >= 0; k--) begin
      step(1, 0, 0, pat[k], 2'($urandom));
      if (k == 2) check("t6 so first", {7'h0, so0}, 8'h01);
      if (k == 1) check("t6 so second", {7'h0, so0}, 8'h00);
    end
    step(1, 1, 0, 1'b1, 2'($urandom));
    check("t6 dout a5", do0, 8'hA5);

    // Randomized traffic with a mid-run reset.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if (n == 150) do_reset();
      step(($urandom % 4) != 0, ($urandom % 12) == 0, ($urandom % 25) == 0,
           1'($urandom), 2'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
